// File: rtl/board_pkg.sv
// Shared constants and types for the board-mark overlay: colours, cell codes, video beat.
package board_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned CODE_W  = 2;

  localparam logic [RGB_W-1:0] BLUE   = 12'h00f;
  localparam logic [RGB_W-1:0] YELLOW = 12'hff0;
  localparam logic [RGB_W-1:0] WHITE  = 12'hfff;

  // Per-cell occupancy code; reserved renders as empty.
  typedef enum logic [CODE_W-1:0] {
    CELL_EMPTY = 2'd0,
    CELL_P0    = 2'd1,
    CELL_P1    = 2'd2,
    CELL_RSVD  = 2'd3
  } cell_code_e;

  // One pixel's worth of timing and colour travelling down the pipeline.
  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               hblnk;
    logic               vsync;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;
  } vid_beat_t;

  // Colour of a cell given its code, win flag and whether winners currently flash white.
  function automatic logic [RGB_W-1:0] mark_colour(input cell_code_e       code,
                                                   input logic             win,
                                                   input logic             win_white,
                                                   input logic [RGB_W-1:0] bg);
    logic [RGB_W-1:0] colour;
    colour = bg;
    case (code)
      CELL_P0: colour = (win && win_white) ? WHITE : BLUE;
      CELL_P1: colour = (win && win_white) ? WHITE : YELLOW;
      default: colour = bg;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/grid_index_decode.sv
// Maps one screen coordinate to a cell index along one axis using constant comparators only.
module grid_index_decode
  import board_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned CELL  = 338,
  parameter int unsigned ORG   = 0,
  parameter int unsigned IDX_W = 2
) (
  input  logic [COORD_W-1:0] coord_i,
  output logic [IDX_W-1:0]   idx_o_c,
  output logic               hit_o_c
);

  // Unrolled range compare; bounds fold to constants at elaboration.
  always_comb begin
    idx_o_c = '0;
    hit_o_c = 1'b0;
    for (int unsigned c = 0; c < N; c++) begin
      if ((32'(coord_i) >= ORG + c * CELL) && (32'(coord_i) < ORG + (c + 1) * CELL)) begin
        idx_o_c = IDX_W'(c);
        hit_o_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_board_marks.sv
// Overlays player marks on a GRID_N x GRID_N board with a fixed two-cycle pipeline.
// Define DRAW_BOARD_MARKS_WIN_BLINK_EN to make winning cells blink between player
// colour and white; otherwise winning cells are solid white.
module draw_board_marks
  import board_pkg::*;
#(
  parameter int unsigned GRID_N       = 3,
  parameter int unsigned CELL_W       = 338,
  parameter int unsigned CELL_H       = 253,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                         pclk,
  input  logic                         rst,
  input  logic [COORD_W-1:0]           hcount_in,
  input  logic [COORD_W-1:0]           vcount_in,
  input  logic                         hsync_in,
  input  logic                         hblnk_in,
  input  logic                         vsync_in,
  input  logic                         vblnk_in,
  input  logic [RGB_W-1:0]             rgb_in,
  input  logic                         start_en,
  input  logic                         choice_en,
  input  logic [2*GRID_N*GRID_N-1:0]   cell_state,
  input  logic [GRID_N*GRID_N-1:0]     win_mask,
  output logic [COORD_W-1:0]           hcount_out,
  output logic [COORD_W-1:0]           vcount_out,
  output logic                         hsync_out,
  output logic                         hblnk_out,
  output logic                         vsync_out,
  output logic                         vblnk_out,
  output logic [RGB_W-1:0]             rgb_out
);

  localparam int unsigned NCELL   = GRID_N * GRID_N;
  localparam int unsigned STATE_W = CODE_W * NCELL;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FCNT_W  = 8;

  // Frame count must fit the counter; an out-of-range value leaves this block empty but visible.
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_blink_frames_out_of_range
  end

  vid_beat_t            in_beat_c;
  vid_beat_t            s1_beat_q;
  vid_beat_t            s2_beat_q;
  vid_beat_t            s2_beat_d;
  logic [IDX_W-1:0]     col_c, row_c;
  logic                 col_hit_c, row_hit_c;
  logic [IDX_W-1:0]     s1_col_q, s1_row_q;
  logic                 s1_inb_q, s1_en_q;
  logic                 draw_en_c;
  logic                 vblnk_rise_c;
  logic [STATE_W-1:0]   shadow_state_q, shadow_state_d;
  logic [NCELL-1:0]     shadow_win_q, shadow_win_d;
  logic                 win_white_c;
  cell_code_e           cell_code_c;
  logic                 cell_win_c;

  assign in_beat_c = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};

  assign draw_en_c    = start_en & ~choice_en;
  assign vblnk_rise_c = vblnk_in & ~s1_beat_q.vblnk;

  grid_index_decode #(.N(GRID_N), .CELL(CELL_W), .ORG(X0), .IDX_W(IDX_W)) u_col_decode (
    .coord_i (hcount_in),
    .idx_o_c (col_c),
    .hit_o_c (col_hit_c)
  );

  grid_index_decode #(.N(GRID_N), .CELL(CELL_H), .ORG(Y0), .IDX_W(IDX_W)) u_row_decode (
    .coord_i (vcount_in),
    .idx_o_c (row_c),
    .hit_o_c (row_hit_c)
  );

  // Stage 1: register the incoming beat with its decoded cell position.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      s1_beat_q <= '0;
      s1_col_q  <= '0;
      s1_row_q  <= '0;
      s1_inb_q  <= 1'b0;
      s1_en_q   <= 1'b0;
    end else begin
      s1_beat_q <= in_beat_c;
      s1_col_q  <= col_c;
      s1_row_q  <= row_c;
      s1_inb_q  <= col_hit_c & row_hit_c;
      s1_en_q   <= draw_en_c;
    end
  end

  // Shadow copies of board state refresh only at the start of vertical blanking.
  always_comb begin
    shadow_state_d = shadow_state_q;
    shadow_win_d   = shadow_win_q;
    if (vblnk_rise_c) begin
      shadow_state_d = cell_state;
      shadow_win_d   = win_mask;
    end
  end

  // Shadow register update.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      shadow_state_q <= '0;
      shadow_win_q   <= '0;
    end else begin
      shadow_state_q <= shadow_state_d;
      shadow_win_q   <= shadow_win_d;
    end
  end

`ifdef DRAW_BOARD_MARKS_WIN_BLINK_EN
  logic              vsync_rise_c;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  assign vsync_rise_c = vsync_in & ~s1_beat_q.vsync;

  // Frame counter toggles the blink phase every BLINK_FRAMES vsyncs; idle while drawing is off.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!draw_en_c) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (vsync_rise_c) begin
      if (frame_cnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCNT_W'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign win_white_c = blink_phase_q;
`else
  assign win_white_c = 1'b1;
`endif

  // Pick the shadowed code and win flag of the cell under the stage-1 pixel, then compose colour.
  always_comb begin
    cell_code_c = CELL_EMPTY;
    cell_win_c  = 1'b0;
    s2_beat_d   = s1_beat_q;
    for (int unsigned r = 0; r < GRID_N; r++) begin
      for (int unsigned c = 0; c < GRID_N; c++) begin
        if (s1_row_q == IDX_W'(r) && s1_col_q == IDX_W'(c)) begin
          cell_code_c = cell_code_e'(shadow_state_q[CODE_W*(r*GRID_N+c) +: CODE_W]);
          cell_win_c  = shadow_win_q[r*GRID_N+c];
        end
      end
    end
    if (s1_en_q && s1_inb_q) begin
      s2_beat_d.rgb = mark_colour(cell_code_c, cell_win_c, win_white_c, s1_beat_q.rgb);
    end
  end

  // Stage 2: final output register.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      s2_beat_q <= '0;
    end else begin
      s2_beat_q <= s2_beat_d;
    end
  end

  assign hcount_out = s2_beat_q.hcount;
  assign vcount_out = s2_beat_q.vcount;
  assign hsync_out  = s2_beat_q.hsync;
  assign hblnk_out  = s2_beat_q.hblnk;
  assign vsync_out  = s2_beat_q.vsync;
  assign vblnk_out  = s2_beat_q.vblnk;
  assign rgb_out    = s2_beat_q.rgb;

endmodule

// File: tb/tb_draw_board_marks.sv
// Directed bench for draw_board_marks (default geometry, BLINK_FRAMES=2).
module tb_draw_board_marks;

  localparam int unsigned GRID_N = 3;
  localparam int unsigned NCELL  = GRID_N * GRID_N;

  logic                 pclk = 1'b0;
  logic                 rst;
  logic [10:0]          hcount_in, vcount_in;
  logic                 hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0]          rgb_in;
  logic                 start_en, choice_en;
  logic [2*NCELL-1:0]   cell_state;
  logic [NCELL-1:0]     win_mask;
  logic [10:0]          hcount_out, vcount_out;
  logic                 hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0]          rgb_out;

  int checks   = 0;
  int failures = 0;

  logic [11:0] rgb_h   [10];
  logic [3:0]  sync_h  [10];
  logic [10:0] hcnt_h  [10];
  logic [11:0] exp_win;

  draw_board_marks #(.GRID_N(GRID_N), .BLINK_FRAMES(2)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .start_en   (start_en),
    .choice_en  (choice_en),
    .cell_state (cell_state),
    .win_mask   (win_mask),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    hsync_in  = 1'b0;
    hblnk_in  = 1'b0;
    vsync_in  = 1'b0;
    vblnk_in  = 1'b0;
  endtask

  // Hold a pixel for two cycles so the output shows exactly that pixel.
  task automatic pix_check(input string tag, input logic [10:0] h, input logic [10:0] v,
                           input logic [11:0] c, input logic [11:0] exp);
    set_pix(h, v, c);
    tick(2);
    chk(tag, 32'(rgb_out), 32'(exp));
  endtask

  task automatic frame_pulse(input logic vb, input logic vs);
    vblnk_in = 1'b0;
    vsync_in = 1'b0;
    tick(1);
    vblnk_in = vb;
    vsync_in = vs;
    tick(1);
    vblnk_in = 1'b0;
    vsync_in = 1'b0;
    tick(2);
  endtask

  task automatic set_cell(input int k, input logic [1:0] code);
    cell_state[2*k +: 2] = code;
  endtask

  initial begin
    // Reset with busy inputs.
    rst        = 1'b0;
    start_en   = 1'b1;
    choice_en  = 1'b0;
    cell_state = '1;
    win_mask   = '1;
    hcount_in  = 11'd400;
    vcount_in  = 11'd300;
    hsync_in   = 1'b1;
    hblnk_in   = 1'b1;
    vsync_in   = 1'b1;
    vblnk_in   = 1'b1;
    rgb_in     = 12'habc;
    tick(2);
    chk("reset_rgb", 32'(rgb_out), 32'h0);
    chk("reset_counts", 32'({hcount_out, vcount_out}), 32'h0);
    chk("reset_strobes", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'h0);

    // Drawing disabled: pure two-cycle delay of random traffic.
    rst        = 1'b1;
    start_en   = 1'b0;
    cell_state = '0;
    win_mask   = '0;
    for (int i = 0; i < 10; i++) begin
      rgb_h[i]  = 12'($urandom);
      sync_h[i] = 4'($urandom);
      hcnt_h[i] = 11'($urandom_range(0, 1013));
      hcount_in = hcnt_h[i];
      vcount_in = 11'd300;
      rgb_in    = rgb_h[i];
      {hsync_in, hblnk_in, vsync_in, vblnk_in} = sync_h[i];
      tick(1);
      if (i == 0) begin
        chk("flush_rgb", 32'(rgb_out), 32'h0);
      end else begin
        chk($sformatf("disabled_rgb_%0d", i), 32'(rgb_out), 32'(rgb_h[i-1]));
        chk($sformatf("disabled_sync_%0d", i),
            32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'(sync_h[i-1]));
        chk($sformatf("disabled_hcnt_%0d", i), 32'(hcount_out), 32'(hcnt_h[i-1]));
      end
    end

    // Basic marks: cell 4 player0, cell 8 player1.
    start_en = 1'b1;
    set_cell(4, 2'd1);
    set_cell(8, 2'd2);
    set_pix(11'd0, 11'd0, 12'h000);
    frame_pulse(1'b1, 1'b0);
    pix_check("p0_cell4", 11'd400, 11'd300, 12'h123, 12'h00f);
    pix_check("p1_cell8", 11'd700, 11'd550, 12'h234, 12'hff0);
    pix_check("empty_cell0", 11'd100, 11'd100, 12'h456, 12'h456);
    pix_check("col0_edge_337", 11'd337, 11'd300, 12'h567, 12'h567);
    pix_check("col1_edge_338", 11'd338, 11'd300, 12'h678, 12'h00f);
    pix_check("above_board_v7", 11'd400, 11'd7, 12'h789, 12'h789);
    pix_check("right_of_board", 11'd1014, 11'd550, 12'h89a, 12'h89a);
    pix_check("bottom_row_last", 11'd1013, 11'd766, 12'h9ab, 12'hff0);
    choice_en = 1'b1;
    pix_check("choice_disables", 11'd400, 11'd300, 12'hbcd, 12'hbcd);
    choice_en = 1'b0;

    // Mid-frame change is invisible until the next vblank rise.
    set_cell(4, 2'd2);
    set_cell(0, 2'd3);
    pix_check("midframe_hold", 11'd400, 11'd300, 12'h111, 12'h00f);
    frame_pulse(1'b1, 1'b0);
    pix_check("after_vblank_new", 11'd400, 11'd300, 12'h222, 12'hff0);
    pix_check("reserved_is_empty", 11'd100, 11'd100, 12'h333, 12'h333);

    // Winning diagonal; combined vblank+vsync latches and counts.
    cell_state = '0;
    set_cell(0, 2'd1);
    set_cell(4, 2'd2);
    set_cell(8, 2'd1);
    set_cell(1, 2'd2);
    win_mask = 9'b100010001;
    frame_pulse(1'b1, 1'b1);
`ifdef DRAW_BOARD_MARKS_WIN_BLINK_EN
    exp_win = 12'h00f;
`else
    exp_win = 12'hfff;
`endif
    pix_check("win_f1_cell0", 11'd100, 11'd100, 12'h444, exp_win);
    pix_check("nonwin_cell1", 11'd400, 11'd100, 12'h555, 12'hff0);
    frame_pulse(1'b0, 1'b1);
    pix_check("win_f2_cell0", 11'd100, 11'd100, 12'h444, 12'hfff);
    frame_pulse(1'b0, 1'b1);
    pix_check("win_f3_cell8", 11'd700, 11'd550, 12'h444, 12'hfff);
    frame_pulse(1'b0, 1'b1);
    pix_check("win_f4_cell0", 11'd100, 11'd100, 12'h444, exp_win);
    frame_pulse(1'b0, 1'b1);
    frame_pulse(1'b0, 1'b1);
    pix_check("win_f6_cell0", 11'd100, 11'd100, 12'h444, 12'hfff);
    choice_en = 1'b1;
    tick(1);
    choice_en = 1'b0;
    pix_check("win_after_disable", 11'd100, 11'd100, 12'h444, exp_win);

    // One-cycle reset mid-line.
    set_pix(11'd400, 11'd300, 12'h321);
    hsync_in = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("midrst_rgb", 32'(rgb_out), 32'h0);
    chk("midrst_counts", 32'({hcount_out, vcount_out}), 32'h0);
    chk("midrst_strobes", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'h0);
    rst = 1'b1;
    tick(1);
    chk("midrst_flush", 32'({hcount_out, rgb_out}), 32'h0);
    tick(1);
    chk("midrst_shadow_empty", 32'(rgb_out), 32'h321);
    chk("midrst_valid_hcnt", 32'(hcount_out), 32'd400);
    chk("midrst_valid_hsync", 32'(hsync_out), 32'h1);
    frame_pulse(1'b1, 1'b0);
`ifdef DRAW_BOARD_MARKS_WIN_BLINK_EN
    exp_win = 12'hff0;
`else
    exp_win = 12'hfff;
`endif
    pix_check("midrst_relatched", 11'd400, 11'd300, 12'h321, exp_win);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
